// File: rtl/red_pitaya_haze_gain_ramp.sv
// -----------------------------------------------------------------------------
// red_pitaya_haze_gain_ramp
//
// Gain sequencer for the haze proportional-gain stage. Slews the gain word kp_o
// from its present value toward a bus-programmed target in fixed-size steps at a
// programmable rate, so a gain change never jumps the servo output.
//
// Ports
//   clk_i     in   1           clock
//   rstn_i    in   1           asynchronous active-low reset
//   kp_o      out  GAINBITS    signed gain word to the gain stage
//   kp_upd_o  out  1           one-cycle pulse, high while kp_o shows a new value
//   busy_o    out  1           ramp in progress
//   done_o    out  1           sticky: last ramp reached its target
//   addr      in   16          bus address
//   wen       in   1           bus write strobe
//   ren       in   1           bus read strobe
//   ack       out  1           bus acknowledge, one cycle after a strobe
//   rdata     out  32          bus read data, one cycle after ren
//   wdata     in   32          bus write data
//
// Register map
//   0x100 CTRL    W: bit0 START, bit1 ABORT (self-clearing); R: {30'b0, done, busy}
//   0x104 TARGET  RW signed target gain, sign-extended on read
//   0x108 STEP    RW unsigned step magnitude (GAINBITS-1 bits)
//   0x10C PERIOD  RW cycles between steps, 0 behaves as 1
//   0x110 KP      R  current kp_o, sign-extended
// -----------------------------------------------------------------------------
module red_pitaya_haze_gain_ramp #(
    parameter int                          GAINBITS   = 24,
    parameter int                          PERIODBITS = 24,
    parameter logic signed [GAINBITS-1:0]  KP_INIT    = '0
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    output logic signed [GAINBITS-1:0] kp_o,
    output logic                       kp_upd_o,
    output logic                       busy_o,
    output logic                       done_o,
    input  logic [15:0]                addr,
    input  logic                       wen,
    input  logic                       ren,
    output logic                       ack,
    output logic [31:0]                rdata,
    input  logic [31:0]                wdata
);

    localparam logic [15:0] ADDR_CTRL   = 16'h0100;
    localparam logic [15:0] ADDR_TARGET = 16'h0104;
    localparam logic [15:0] ADDR_STEP   = 16'h0108;
    localparam logic [15:0] ADDR_PERIOD = 16'h010C;
    localparam logic [15:0] ADDR_KP     = 16'h0110;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    state_t state, state_next;

    // Programmed configuration
    logic signed [GAINBITS-1:0] target;
    logic [GAINBITS-2:0]        step;
    logic [PERIODBITS-1:0]      period;
    logic [PERIODBITS-1:0]      counter;

    // Command decode
    logic ctrl_wr, start, abort;
    logic [31:0] rdata_next;

    // Step arithmetic
    logic [PERIODBITS-1:0]      period_eff;
    logic                       tick;
    logic signed [GAINBITS:0]   diff;
    logic [GAINBITS:0]          diff_mag;
    logic                       snap;
    logic signed [GAINBITS-1:0] kp_stepped;
    logic signed [GAINBITS-1:0] kp_next;

    // Upper write-data bits carry no register content.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:GAINBITS];

    assign ctrl_wr = wen && (addr == ADDR_CTRL);
    // ABORT dominates a simultaneous START.
    assign abort   = ctrl_wr && wdata[1];
    assign start   = ctrl_wr && wdata[0] && !wdata[1];

    assign period_eff = (period == '0) ? PERIODBITS'(1) : period;
    // ">=" rather than "==" so a PERIOD shrunk below the running count fires
    // on the very next cycle instead of waiting for the counter to wrap.
    assign tick = (state == RAMP) && (counter >= period_eff - PERIODBITS'(1));

    // Difference is one bit wider than the gain word so full-scale swings
    // (e.g. -2^23 to 2^23-1) cannot overflow.
    assign diff     = {target[GAINBITS-1], target} - {kp_o[GAINBITS-1], kp_o};
    assign diff_mag = diff[GAINBITS] ? $unsigned(-diff) : $unsigned(diff);
    assign snap     = (step == '0) || (diff_mag <= {2'b00, step});

    // Only reached when |diff| > step, so the result lies strictly between
    // kp_o and target and cannot wrap at GAINBITS width.
    assign kp_stepped = diff[GAINBITS] ? kp_o - $signed({1'b0, step})
                                       : kp_o + $signed({1'b0, step});
    assign kp_next    = snap ? target : kp_stepped;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments and the async
    // reset in the sensitivity list, so all registers see pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: combinational blocks assign a default first so no path can infer
    // a latch.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = RAMP;
        end else if (tick && snap) begin
            state_next = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy_o = (state == RAMP);
    end

    // -------------------------------------------------------------------------
    // Ramp datapath: gain word, step counter, update pulse, done flag.
    // START restarts the period count and suppresses a coincident tick.
    // kp_upd_o is registered alongside kp_o so it is high exactly during the
    // first cycle kp_o presents a changed value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            kp_o     <= KP_INIT;
            counter  <= '0;
            kp_upd_o <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            kp_upd_o <= 1'b0;
            if (abort) begin
                counter <= '0;
                done_o  <= 1'b0;
            end else if (start) begin
                counter <= '0;
                done_o  <= 1'b0;
            end else if (state == RAMP) begin
                if (tick) begin
                    counter  <= '0;
                    kp_o     <= kp_next;
                    kp_upd_o <= (kp_next != kp_o);
                    if (snap) begin
                        done_o <= 1'b1;
                    end
                end else begin
                    counter <= counter + PERIODBITS'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Configuration registers. A write landing on a tick edge is seen by the
    // following tick; the current tick already used the old value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            target <= '0;
            step   <= '0;
            period <= '0;
        end else if (wen) begin
            case (addr)
                ADDR_TARGET: target <= $signed(wdata[GAINBITS-1:0]);
                ADDR_STEP:   step   <= wdata[GAINBITS-2:0];
                ADDR_PERIOD: period <= wdata[PERIODBITS-1:0];
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus read path
    // -------------------------------------------------------------------------
    always_comb begin
        rdata_next = '0;
        case (addr)
            ADDR_CTRL:   rdata_next = {30'b0, done_o, busy_o};
            ADDR_TARGET: rdata_next = {{(32-GAINBITS){target[GAINBITS-1]}}, target};
            ADDR_STEP:   rdata_next = 32'(step);
            ADDR_PERIOD: rdata_next = 32'(period);
            ADDR_KP:     rdata_next = {{(32-GAINBITS){kp_o[GAINBITS-1]}}, kp_o};
            default:     rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ack   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= wen | ren;
            rdata <= ren ? rdata_next : 32'd0;
        end
    end

endmodule

// File: tb/tb_red_pitaya_haze_gain_ramp.sv
// -----------------------------------------------------------------------------
// Directed testbench for red_pitaya_haze_gain_ramp.
// Inputs are driven and outputs sampled just after the falling edge; the DUT
// acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_red_pitaya_haze_gain_ramp;

    logic               clk_i;
    logic               rstn_i;
    logic signed [23:0] kp_o;
    logic               kp_upd_o;
    logic               busy_o;
    logic               done_o;
    logic [15:0]        addr;
    logic               wen;
    logic               ren;
    logic               ack;
    logic [31:0]        rdata;
    logic [31:0]        wdata;

    int total = 0;
    int bad   = 0;

    int up_exp   [4] = '{300, 600, 900, 1000};
    int down_exp [4] = '{600, 200, -200, -500};
    int edge_exp [3] = '{-1, 8388606, 8388607};

    red_pitaya_haze_gain_ramp dut (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .kp_o     (kp_o),
        .kp_upd_o (kp_upd_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .addr     (addr),
        .wen      (wen),
        .ren      (ren),
        .ack      (ack),
        .rdata    (rdata),
        .wdata    (wdata)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        wen   = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk_i);
        wen   = 1'b0;
        wdata = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] exp, input string tag);
        ren  = 1'b1;
        addr = a;
        @(negedge clk_i);
        ren  = 1'b0;
        check({tag, "_ack"}, 32'(ack), 32'd1);
        check(tag, rdata, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rstn_i = 1'b0;
        addr   = '0;
        wen    = 1'b0;
        ren    = 1'b0;
        wdata  = '0;

        // ---------------- reset state ----------------
        cycles(2);
        check("rst_kp",    32'(kp_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rstn_i = 1'b1;
        cycles(1);

        // ---------------- up ramp ----------------
        bus_write(16'h0104, 32'd1000);
        bus_write(16'h0108, 32'd300);
        bus_write(16'h010C, 32'd4);
        bus_write(16'h0100, 32'd1);
        check("up_busy0", 32'(busy_o), 32'd1);
        check("up_kp0",   32'(kp_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycles(3);
            check("up_hold", 32'(kp_o), (k == 0) ? 32'd0 : 32'(up_exp[k-1]));
            check("up_noupd", 32'(kp_upd_o), 32'd0);
            cycles(1);
            check("up_kp",  32'(kp_o), 32'(up_exp[k]));
            check("up_upd", 32'(kp_upd_o), 32'd1);
        end
        check("up_busy_end", 32'(busy_o), 32'd0);
        check("up_done_end", 32'(done_o), 32'd1);
        bus_read(16'h0110, 32'd1000, "up_rd_kp");
        bus_read(16'h0100, 32'd2, "up_rd_ctrl");

        // ---------------- down ramp through zero ----------------
        bus_write(16'h0104, 32'hFFFF_FE0C);   // -500
        bus_write(16'h0108, 32'd400);
        bus_write(16'h010C, 32'd1);
        bus_write(16'h0100, 32'd1);
        check("dn_kp0",   32'(kp_o), 32'd1000);
        check("dn_done0", 32'(done_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cycles(1);
            check("dn_kp",  32'(kp_o), 32'(down_exp[k]));
            check("dn_upd", 32'(kp_upd_o), 32'd1);
        end
        check("dn_busy_end", 32'(busy_o), 32'd0);
        check("dn_done_end", 32'(done_o), 32'd1);
        bus_read(16'h0104, 32'hFFFF_FE0C, "dn_rd_target");

        // ---------------- snap to negative full scale ----------------
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0104, 32'h0080_0000);   // -2^23
        bus_write(16'h010C, 32'd0);
        bus_write(16'h0100, 32'd1);
        check("snap_busy0", 32'(busy_o), 32'd1);
        cycles(1);
        check("snap_kp",   32'(kp_o), 32'hFF80_0000);
        check("snap_upd",  32'(kp_upd_o), 32'd1);
        check("snap_busy", 32'(busy_o), 32'd0);
        check("snap_done", 32'(done_o), 32'd1);

        // ---------------- full-scale swing to positive max ----------------
        bus_write(16'h0104, 32'h007F_FFFF);
        bus_write(16'h0108, 32'h007F_FFFF);
        bus_write(16'h0100, 32'd1);
        for (int k = 0; k < 3; k++) begin
            cycles(1);
            check("fs_kp", 32'(kp_o), 32'(edge_exp[k]));
        end
        check("fs_done", 32'(done_o), 32'd1);

        // ---------------- already at target: no pulse ----------------
        bus_write(16'h0100, 32'd1);
        check("at_done0", 32'(done_o), 32'd0);
        cycles(1);
        check("at_kp",   32'(kp_o), 32'd8388607);
        check("at_upd",  32'(kp_upd_o), 32'd0);
        check("at_done", 32'(done_o), 32'd1);

        // ---------------- abort ----------------
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0104, 32'd0);
        bus_write(16'h0100, 32'd1);
        cycles(1);
        check("ab_zero", 32'(kp_o), 32'd0);
        bus_write(16'h0104, 32'd10000);
        bus_write(16'h0108, 32'd10);
        bus_write(16'h010C, 32'd2);
        bus_write(16'h0100, 32'd1);
        cycles(20);
        check("ab_kp20", 32'(kp_o), 32'd100);
        bus_write(16'h0100, 32'd2);
        check("ab_busy", 32'(busy_o), 32'd0);
        check("ab_done", 32'(done_o), 32'd0);
        check("ab_kp",   32'(kp_o), 32'd100);
        cycles(6);
        check("ab_frozen", 32'(kp_o), 32'd100);
        bus_write(16'h0100, 32'd3);
        check("sa_busy", 32'(busy_o), 32'd0);
        cycles(4);
        check("sa_kp",   32'(kp_o), 32'd100);
        check("sa_busy2", 32'(busy_o), 32'd0);

        // ---------------- bus reads ----------------
        bus_read(16'h0100, 32'd0,     "rd_ctrl");
        bus_read(16'h0104, 32'd10000, "rd_target");
        bus_read(16'h0108, 32'd10,    "rd_step");
        bus_read(16'h010C, 32'd2,     "rd_period");
        bus_read(16'h0110, 32'd100,   "rd_kp");
        bus_read(16'h01FC, 32'd0,     "rd_unmapped");
        cycles(1);
        check("rd_ack_drop", 32'(ack), 32'd0);
        bus_write(16'h0110, 32'd1234);
        check("wr_ack", 32'(ack), 32'd1);
        bus_read(16'h0110, 32'd100, "rd_kp_ro");

        // ---------------- target rewrite mid-ramp ----------------
        bus_write(16'h0108, 32'd0);
        bus_write(16'h0104, 32'd0);
        bus_write(16'h010C, 32'd0);
        bus_write(16'h0100, 32'd1);
        cycles(1);
        check("rv_zero", 32'(kp_o), 32'd0);
        bus_write(16'h0104, 32'd1000);
        bus_write(16'h0108, 32'd300);
        bus_write(16'h010C, 32'd4);
        bus_write(16'h0100, 32'd1);
        cycles(8);
        check("rv_kp600", 32'(kp_o), 32'd600);
        bus_write(16'h0104, 32'd200);
        cycles(3);
        check("rv_kp300", 32'(kp_o), 32'd300);
        check("rv_busy",  32'(busy_o), 32'd1);
        cycles(4);
        check("rv_kp200", 32'(kp_o), 32'd200);
        check("rv_done",  32'(done_o), 32'd1);
        check("rv_idle",  32'(busy_o), 32'd0);

        // ---------------- asynchronous reset mid-ramp ----------------
        bus_write(16'h0104, 32'd1000);
        bus_write(16'h0100, 32'd1);
        cycles(5);
        check("ar_kp_pre", 32'(kp_o), 32'd500);
        ren  = 1'b1;
        addr = 16'h0110;
        @(posedge clk_i);
        #2;
        check("ar_ack_pre", 32'(ack), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("ar_kp",   32'(kp_o), 32'd0);
        check("ar_busy", 32'(busy_o), 32'd0);
        check("ar_done", 32'(done_o), 32'd0);
        check("ar_ack",  32'(ack), 32'd0);
        check("ar_rdata", rdata, 32'd0);
        @(negedge clk_i);
        ren = 1'b0;
        cycles(1);
        rstn_i = 1'b1;
        cycles(2);
        check("ar_kp_post", 32'(kp_o), 32'd0);
        bus_read(16'h0104, 32'd0, "ar_rd_target");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
